// File: rtl/reg_ring_pkg.sv
// Shared types and constants for the circular register ring rotator.
package reg_ring_pkg;

  // Controller states: waiting for a command, or stepping the ring.
  typedef enum logic {
    IDLE   = 1'b0,
    ROTATE = 1'b1
  } state_e;

  // Rotation direction encodings as seen on the dir input.
  localparam logic DIR_DOWN = 1'b0;  // stage[i] takes stage[i+1]
  localparam logic DIR_UP   = 1'b1;  // stage[i] takes stage[i-1]

endpackage

// File: rtl/reg_ring_rotator.sv
// Circular register ring of DEPTH stages, WIDTH bits each. Supports a parallel
// load and multi-step rotation in either direction with busy/done status.
module reg_ring_rotator
  import reg_ring_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 3,
  parameter int STEP_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [DEPTH*WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic                   dir,
  input  logic [STEP_W-1:0]      steps,
  output logic [DEPTH*WIDTH-1:0] ring_data,
  output logic                   busy,
  output logic                   done
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [DEPTH-1:0][WIDTH-1:0] rot_down, rot_up;
  state_e                      state_q, state_d;
  logic                        dir_q, dir_d;
  logic [STEP_W-1:0]           rem_q, rem_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  // Neighbour taps for each stage; both directions wrap around the ring ends.
  for (genvar i = 0; i < DEPTH; i++) begin : g_tap
    localparam int NXT = (i + 1) % DEPTH;
    localparam int PRV = (i + DEPTH - 1) % DEPTH;
    assign rot_down[i] = stage_q[NXT];
    assign rot_up[i]   = stage_q[PRV];
  end

  // Next-state logic: commands only in IDLE, load wins over start.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          stage_d = load_data;
        end else if (start) begin
          if (steps == '0) begin
            done_d = 1'b1;
          end else begin
            dir_d   = dir;
            rem_d   = steps;
            state_d = ROTATE;
            busy_d  = 1'b1;
          end
        end
      end
      ROTATE: begin
        // Whole ring shifts from pre-edge values, so nothing is lost or duplicated.
        stage_d = (dir_q == DIR_UP) ? rot_up : rot_down;
        rem_d   = rem_q - STEP_W'(1);
        busy_d  = 1'b1;
        if (rem_q == STEP_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, stage register file and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      dir_q   <= DIR_DOWN;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ring_data = stage_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_ring_rotator.sv
// Directed, table-driven bench for reg_ring_rotator (WIDTH=8, DEPTH=3).
module tb_reg_ring_rotator;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 3;
  localparam int STEP_W = 3;
  localparam int RW     = WIDTH * DEPTH;

  // Packed as {stage2, stage1, stage0}
  localparam logic [RW-1:0] R_5_10_0 = 24'h000A05;
  localparam logic [RW-1:0] R_10_0_5 = 24'h05000A;
  localparam logic [RW-1:0] R_0_5_10 = 24'h0A0500;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load = 1'b0;
  logic [RW-1:0]     load_data = '0;
  logic              start = 1'b0;
  logic              dir = 1'b0;
  logic [STEP_W-1:0] steps = '0;
  logic [RW-1:0]     ring_data;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic              ld;
    logic [RW-1:0]     ldat;
    logic              st;
    logic              dr;
    logic [STEP_W-1:0] stp;
    logic [RW-1:0]     ring;
    logic              bsy;
    logic              dn;
  } vec_t;

  vec_t vt[25];

  reg_ring_rotator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data), .start(start),
    .dir(dir), .steps(steps), .ring_data(ring_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic ld, logic [RW-1:0] ldat, logic st, logic dr,
                              logic [STEP_W-1:0] stp, logic [RW-1:0] ring,
                              logic bsy, logic dn);
    vec_t v;
    v.ld = ld; v.ldat = ldat; v.st = st; v.dr = dr; v.stp = stp;
    v.ring = ring; v.bsy = bsy; v.dn = dn;
    return v;
  endfunction

  task automatic chk(string name, logic [RW-1:0] er, logic eb, logic ed);
    checks++;
    if (ring_data !== er) begin
      errors++;
      $display("FAIL %s ring_data: got %h expected %h", name, ring_data, er);
    end
    checks++;
    if (busy !== eb) begin
      errors++;
      $display("FAIL %s busy: got %b expected %b", name, busy, eb);
    end
    checks++;
    if (done !== ed) begin
      errors++;
      $display("FAIL %s done: got %b expected %b", name, done, ed);
    end
  endtask

  task automatic drive(logic ld, logic [RW-1:0] ldat, logic st, logic dr, logic [STEP_W-1:0] stp);
    load = ld; load_data = ldat; start = st; dir = dr; steps = stp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ld, ldat, st, dr, steps -> ring, busy, done (after the edge)
    vt[0]  = mk(1, R_5_10_0, 0, 0, 0, R_5_10_0, 0, 0);  // load
    vt[1]  = mk(0, '0,       0, 0, 0, R_5_10_0, 0, 0);
    vt[2]  = mk(0, '0,       1, 0, 1, R_5_10_0, 1, 0);  // down x1
    vt[3]  = mk(0, '0,       0, 0, 0, R_10_0_5, 0, 1);
    vt[4]  = mk(0, '0,       1, 0, 1, R_10_0_5, 1, 0);  // back-to-back in done cycle
    vt[5]  = mk(0, '0,       0, 0, 0, R_0_5_10, 0, 1);
    vt[6]  = mk(0, '0,       1, 0, 1, R_0_5_10, 1, 0);
    vt[7]  = mk(0, '0,       0, 0, 0, R_5_10_0, 0, 1);
    vt[8]  = mk(0, '0,       1, 1, 4, R_5_10_0, 1, 0);  // up x4
    vt[9]  = mk(0, '0,       0, 0, 0, R_0_5_10, 1, 0);
    vt[10] = mk(0, '0,       0, 0, 0, R_10_0_5, 1, 0);
    vt[11] = mk(0, '0,       0, 0, 0, R_5_10_0, 1, 0);
    vt[12] = mk(0, '0,       0, 0, 0, R_0_5_10, 0, 1);
    vt[13] = mk(0, '0,       0, 0, 0, R_0_5_10, 0, 0);
    vt[14] = mk(0, '0,       1, 0, 0, R_0_5_10, 0, 1);  // steps=0
    vt[15] = mk(0, '0,       0, 0, 0, R_0_5_10, 0, 0);
    vt[16] = mk(1, R_5_10_0, 1, 0, 1, R_5_10_0, 0, 0);  // load beats start
    vt[17] = mk(0, '0,       0, 0, 0, R_5_10_0, 0, 0);
    vt[18] = mk(0, '0,       1, 0, 5, R_5_10_0, 1, 0);  // down x5 with noise
    vt[19] = mk(1, 24'hFFFFFF, 1, 1, 2, R_10_0_5, 1, 0);
    vt[20] = mk(0, '0,       1, 1, 7, R_0_5_10, 1, 0);
    vt[21] = mk(1, 24'h123456, 0, 1, 0, R_5_10_0, 1, 0);
    vt[22] = mk(0, '0,       0, 1, 0, R_10_0_5, 1, 0);
    vt[23] = mk(0, '0,       0, 0, 0, R_0_5_10, 0, 1);
    vt[24] = mk(0, '0,       0, 0, 0, R_0_5_10, 0, 0);

    #12;
    chk("reset", '0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      drive(vt[i].ld, vt[i].ldat, vt[i].st, vt[i].dr, vt[i].stp);
      tick();
      chk($sformatf("vec%0d", i), vt[i].ring, vt[i].bsy, vt[i].dn);
    end

    // Async reset in the middle of a 6-step rotation.
    drive(1, R_5_10_0, 0, 0, 0);
    tick();
    drive(0, '0, 1, 0, 6);
    tick();
    chk("abort_t0", R_5_10_0, 1, 0);
    drive(0, '0, 0, 0, 0);
    tick();
    chk("abort_t1", R_10_0_5, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_async", '0, 0, 0);
    tick();
    chk("abort_hold", '0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("abort_no_done", '0, 0, 0);

    // Fresh command after reset release: load then up x2.
    drive(1, R_5_10_0, 0, 0, 0);
    tick();
    chk("post_load", R_5_10_0, 0, 0);
    drive(0, '0, 1, 1, 2);
    tick();
    chk("post_start", R_5_10_0, 1, 0);
    drive(0, '0, 0, 0, 0);
    begin
      int n;
      n = 0;
      while (done !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      checks++;
      if (n != 2) begin
        errors++;
        $display("FAIL post_latency: got %0d cycles expected 2", n);
      end
    end
    chk("post_done", R_10_0_5, 0, 1);
    tick();
    chk("post_idle", R_10_0_5, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_ring_rotator.md
# reg_ring_rotator

Parametrised circular register ring of DEPTH stages, each WIDTH bits, rotated one position per clock under a start/steps command. It generalises the fixed three-register non-blocking rotation (stage i takes stage i+1 and the last stage takes stage 0, all updated concurrently) with:
- a parallel load;
- selectable direction;
- a multi-step rotation counter;
- busy/done status.

It is a reusable building block for rotation/scheduling demos and round-robin data paths.

## Interface
- WIDTH, 8, bits per stage
- DEPTH, 3, number of stages (>= 2)
- STEP_W, $clog2(DEPTH)+1, width of steps request
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- load  input  1  parallel load request (honoured in IDLE only)
- load_data  input  DEPTH*WIDTH  load value; stage i = bits [i*WIDTH +: WIDTH]
- start  input  1  begin rotation (honoured in IDLE only)
- dir  input  1  0 = down (stage[i] <= stage[i+1]); 1 = up (stage[i] <= stage[i-1])
- steps  input  STEP_W  number of single-position rotations to perform
- ring_data  output  DEPTH*WIDTH  current stage contents, same packing as load_data
- busy  output  1  high while rotating
- done  output  1  one-cycle pulse when a command completes

## Operation
- One clock (clk); asynchronous, active-high reset (rst).
- Reset (async assert) clears:
  - all stages to 0;
  - busy = 0, done = 0;
  - state = IDLE, remaining = 0.
- States:
  - IDLE:
    - load = 1: all stages take load_data. Load has priority over a same-cycle start; start is ignored.
    - start = 1, load = 0, steps = 0: no rotation; done pulses; stay IDLE.
    - start = 1, load = 0, steps > 0: latch dir and steps into dir_q and remaining; go to ROTATE.
  - ROTATE:
    - Every cycle, all stages update concurrently, one position in direction dir_q. remaining decrements.
    - When remaining == 1 on a rotating edge: go to IDLE; done = 1 for the next cycle.
    - load and start are ignored while busy.
- Rotation is always concurrent: every stage samples the pre-edge value of its neighbour, so no data is duplicated or lost.
- Wrap-around:
  - dir 0: stage[DEPTH-1] takes stage[0].
  - dir 1: stage[0] takes stage[DEPTH-1].
- steps >= DEPTH is legal and performs exactly steps single rotations. The net effect equals steps mod DEPTH.
- Changing dir or steps during ROTATE has no effect, because both are latched at start.
- rst asserted mid-rotation aborts immediately: stages go to 0, no done pulse.

## Timing
- Command (start with steps = N > 0) sampled at edge t0.
  - busy = 1 from t0 until tN.
  - Rotations occur at edges t1..tN.
  - At tN: busy = 0, done = 1, and ring_data shows the final value in that same cycle.
  - done clears at tN+1.
- start with steps = 0 at t0: done = 1 after t0 for one cycle; busy stays 0.
- Load is visible on ring_data one cycle after its sampling edge.
- A new start is accepted at tN (the done cycle is IDLE), giving back-to-back commands with no gap.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package reg_ring_pkg holds:
  - the state enum (IDLE, ROTATE);
  - direction constants DIR_DOWN = 0, DIR_UP = 1.
- Keep a single flat module with no sub-module. The stage array is a generate-indexed register file updated in one clocked block with non-blocking assignments.

## Test plan
All scenarios use WIDTH = 8, DEPTH = 3. Stage lists are written stage0, stage1, stage2.
- Reset then load {0, 10, 5} (stage0 = 5, stage1 = 10, stage2 = 0) → ring_data reads 5, 10, 0 one cycle later; busy = 0, done = 0.
- start, dir = 0, steps = 1 → after 1 edge the stages read 10, 0, 5; done pulses once. Repeat twice → 0, 5, 10, then back to 5, 10, 0.
- start, dir = 1, steps = 4 → busy for exactly 4 cycles; final stages read 0, 5, 10 (net 1 up); done is coincident with the final value.
- steps = 0 → done pulses the next cycle, busy never rises, data unchanged. start together with load in IDLE → load applied, no rotation.
- During a steps = 5 rotation, pulse load and start, and toggle dir → all ignored; exactly 5 rotations in the original direction.
- Assert rst asynchronously (mid-cycle) at cycle 2 of a steps = 6 rotation → stages, busy and done go to 0 immediately with no done pulse. After release, a new command executes normally.
